// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: pad input synchroniser, per-bit debounce, edge
// detect and sticky interrupt status for the register block GPIO inputs.
//
// Ports:
//   WBs_CLK_i       single clock for the whole block
//   WBs_RST_i       synchronous active-high reset
//   GPIO_PAD_i      raw asynchronous pad inputs
//   Debounce_Len_i  stable cycles required to accept a change (0 acts as 1)
//   Int_Rise_En_i   per-bit rising-edge interrupt enable
//   Int_Fall_En_i   per-bit falling-edge interrupt enable
//   Int_Clr_i       per-bit write-1-to-clear strobe for status
//   Event_Cnt_Clr_i clear strobe for the event counter
//   GPIO_IN_o       debounced, synchronised GPIO value
//   Int_Status_o    sticky per-bit edge status
//   Int_o           registered OR of Int_Status_o
//   Event_Cnt_o     qualifying-edge event count
//
// Optional feature: define GPIO_IN_EVENT_CNT_EN to build the saturating
// 16-bit event counter; otherwise Event_Cnt_o is tied to zero.

module gpio_in_conditioner #(
    parameter int GPIO_WIDTH   = 46,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CNT_WIDTH = 8
) (
    input  logic                    WBs_CLK_i,
    input  logic                    WBs_RST_i,
    input  logic [GPIO_WIDTH-1:0]   GPIO_PAD_i,
    input  logic [DB_CNT_WIDTH-1:0] Debounce_Len_i,
    input  logic [GPIO_WIDTH-1:0]   Int_Rise_En_i,
    input  logic [GPIO_WIDTH-1:0]   Int_Fall_En_i,
    input  logic [GPIO_WIDTH-1:0]   Int_Clr_i,
    input  logic                    Event_Cnt_Clr_i,
    output logic [GPIO_WIDTH-1:0]   GPIO_IN_o,
    output logic [GPIO_WIDTH-1:0]   Int_Status_o,
    output logic                    Int_o,
    output logic [15:0]             Event_Cnt_o
);

    logic [GPIO_WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0]   s;
    logic [DB_CNT_WIDTH-1:0] cnt_q [GPIO_WIDTH];
    logic [DB_CNT_WIDTH-1:0] len_m1;
    logic [GPIO_WIDTH-1:0]   upd;
    logic [GPIO_WIDTH-1:0]   rise;
    logic [GPIO_WIDTH-1:0]   fall;
    logic [GPIO_WIDTH-1:0]   set;

    assign s = sync_q[SYNC_STAGES-1];

    // A length of 0 behaves as 1, so the terminal count is never below 0.
    assign len_m1 = (Debounce_Len_i == '0) ? '0 : Debounce_Len_i - 1'b1;

    always_comb begin
        upd = '0;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            upd[i] = (s[i] != GPIO_IN_o[i]) && (cnt_q[i] == len_m1);
        end
    end

    // Edges are taken from the update itself so they coincide with the
    // cycle GPIO_IN_o changes.
    assign rise = upd & s;
    assign fall = upd & ~s;
    assign set  = (rise & Int_Rise_En_i) | (fall & Int_Fall_En_i);

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= GPIO_PAD_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            GPIO_IN_o <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (s[i] == GPIO_IN_o[i] || upd[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
            GPIO_IN_o <= (GPIO_IN_o & ~upd) | (s & upd);
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            Int_Status_o <= '0;
            Int_o        <= 1'b0;
        end else begin
            Int_Status_o <= (Int_Status_o & ~Int_Clr_i) | set;
            Int_o        <= |Int_Status_o;
        end
    end

`ifdef GPIO_IN_EVENT_CNT_EN
    // One count per cycle with any qualifying edge; clear beats increment.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i || Event_Cnt_Clr_i) begin
            Event_Cnt_o <= '0;
        end else if ((|set) && (Event_Cnt_o != 16'hFFFF)) begin
            Event_Cnt_o <= Event_Cnt_o + 16'd1;
        end
    end
`else
    logic unused_event_clr;
    assign unused_event_clr = Event_Cnt_Clr_i;
    assign Event_Cnt_o      = 16'h0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed bench for gpio_in_conditioner with a
// cycle model checked every cycle plus hand-computed literal checks.

module tb_gpio_in_conditioner;

    localparam int W  = 46;
    localparam int SS = 2;
    localparam int CW = 8;
`ifdef GPIO_IN_EVENT_CNT_EN
    localparam bit EV_EN = 1'b1;
`else
    localparam bit EV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pad;
    logic [CW-1:0] len;
    logic [W-1:0]  ren;
    logic [W-1:0]  fen;
    logic [W-1:0]  clr;
    logic          ecl;
    logic [W-1:0]  gin;
    logic [W-1:0]  st;
    logic          io;
    logic [15:0]   ev;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    gpio_in_conditioner #(
        .GPIO_WIDTH  (W),
        .SYNC_STAGES (SS),
        .DB_CNT_WIDTH(CW)
    ) dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .GPIO_PAD_i     (pad),
        .Debounce_Len_i (len),
        .Int_Rise_En_i  (ren),
        .Int_Fall_En_i  (fen),
        .Int_Clr_i      (clr),
        .Event_Cnt_Clr_i(ecl),
        .GPIO_IN_o      (gin),
        .Int_Status_o   (st),
        .Int_o          (io),
        .Event_Cnt_o    (ev)
    );

    // Model: pad samples pass through a delay queue, then each bit tracks
    // how long the synchronised value has disagreed with the output.
    logic [W-1:0] q_m[$];
    logic [W-1:0] gin_m;
    logic [W-1:0] st_m;
    logic         io_m;
    logic [15:0]  ev_m;
    int           run_m[W];

    always @(posedge clk) begin : model
        logic [W-1:0] sv;
        logic [W-1:0] ed;
        int           l;
        if (rst) begin
            q_m = {};
            for (int k = 0; k < SS; k++) q_m.push_back('0);
            gin_m = '0;
            st_m  = '0;
            io_m  = 1'b0;
            ev_m  = '0;
            for (int i = 0; i < W; i++) run_m[i] = 0;
        end else begin
            sv = q_m.pop_front();
            q_m.push_back(pad);
            l  = (len == 0) ? 1 : int'(len);
            io_m = (st_m != '0);
            ed = '0;
            for (int i = 0; i < W; i++) begin
                if (sv[i] == gin_m[i]) begin
                    run_m[i] = 0;
                end else if (run_m[i] + 1 >= l) begin
                    run_m[i] = 0;
                    gin_m[i] = sv[i];
                    if (sv[i] ? ren[i] : fen[i]) ed[i] = 1'b1;
                end else begin
                    run_m[i] = run_m[i] + 1;
                end
            end
            st_m = (st_m & ~clr) | ed;
            if (EV_EN) begin
                if (ecl) ev_m = '0;
                else if (ed != '0 && ev_m != 16'hFFFF) ev_m = ev_m + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (gin !== gin_m || st !== st_m || io !== io_m || ev !== ev_m) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t gin=%h/%h st=%h/%h int=%b/%b ev=%h/%h",
                         $time, gin, gin_m, st, st_m, io, io_m, ev, ev_m);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        pad = '0;
        len = 8'd4;
        ren = '0;
        fen = '0;
        clr = '0;
        ecl = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_gin", gin, 0);
        chk("reset_st", st, 0);
        chk("reset_int", io, 0);
        chk("reset_ev", ev, 0);
        repeat (3) tick();
        chk("idle_gin", gin, 0);

        pad[0] = 1'b1;
        n = 0;
        while (!gin[0] && n < 20) begin tick(); n++; end
        chk("lat_len4", n, SS + 4);

        ren[5] = 1'b1;
        pad[5] = 1'b1;
        repeat (3) tick();
        pad[5] = 1'b0;
        repeat (10) tick();
        chk("glitch_gin", gin[5], 0);
        chk("glitch_st", st[5], 0);

        ren[3] = 1'b1;
        fen[3] = 1'b0;
        len    = 8'd2;
        pad[3] = 1'b1;
        n = 0;
        while (!st[3] && n < 20) begin tick(); n++; end
        chk("rise_lat", n, SS + 2);
        chk("int_lag0", io, 0);
        tick();
        chk("int_lag1", io, 1);
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        chk("clr_st", st[3], 0);
        chk("clr_int_hold", io, 1);
        tick();
        chk("clr_int_drop", io, 0);
        repeat (3) tick();
        pad[3] = 1'b0;
        repeat (10) tick();
        chk("fall_gin", gin[3], 0);
        chk("fall_no_set", st[3], 0);

        clr[3] = 1'b1;
        pad[3] = 1'b1;
        n = 0;
        while (!gin[3] && n < 20) begin tick(); n++; end
        chk("coll_st", st[3], 1);
        clr[3] = 1'b0;
        tick();
        chk("coll_hold", st[3], 1);
        clr[3] = 1'b1;
        tick();
        clr[3] = 1'b0;
        chk("clr2_st", st[3], 0);
        chk("clr2_int_hold", io, 1);
        tick();
        chk("clr2_int_drop", io, 0);

        len    = 8'd0;
        pad[7] = 1'b1;
        n = 0;
        while (!gin[7] && n < 20) begin tick(); n++; end
        chk("lat_len0", n, SS + 1);

        len    = 8'd8;
        pad[8] = 1'b1;
        repeat (4) tick();
        rst     = 1'b1;
        ren[10] = 1'b1;
        pad[10] = 1'b1;
        tick();
        chk("midrst_gin", gin, 0);
        chk("midrst_st", st, 0);
        chk("midrst_int", io, 0);
        chk("midrst_ev", ev, 0);
        rst = 1'b0;
        n = 0;
        while (!st[10] && n < 40) begin tick(); n++; end
        chk("post_rst_lat", n, SS + 8);
        chk("post_rst_gin", gin[10], 1);

        len       = 8'd1;
        ren[21:20] = 2'b11;
        fen[21:20] = 2'b11;
        ecl = 1'b1;
        tick();
        ecl = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pad[21:20] = ~pad[21:20];
            repeat (6) tick();
        end
        chk("ev_three", ev, EV_EN ? 3 : 0);
        ecl = 1'b1;
        pad[21:20] = ~pad[21:20];
        repeat (6) tick();
        ecl = 1'b0;
        chk("ev_clr_wins", ev, 0);

        if (EV_EN) begin
            ren[22] = 1'b1;
            fen[22] = 1'b1;
            for (int k = 0; k < 65540; k++) begin
                pad[22] = ~pad[22];
                tick();
            end
            repeat (4) tick();
            chk("ev_saturate", ev, 16'hFFFF);
        end else begin
            chk("ev_const0", ev, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
